// File: rtl/pixel_sensor_ctrl.sv
// pixel_sensor_ctrl: phase sequencer for a 2x2 pixel array.
// Generates erase/expose/convert/read1/read2 phases separated by one-cycle
// gaps, drives the digital ramp code during conversion, captures the four
// pixel values at the end of each read phase and flags a completed frame.
module pixel_sensor_ctrl #(
    parameter int C_ERASE   = 5,
    parameter int C_EXPOSE  = 255,
    parameter int C_CONVERT = 255,
    parameter int C_READ    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       erase,
    output logic       expose,
    output logic       convert,
    output logic       read1,
    output logic       read2,
    output logic [7:0] rampCode,
    output logic       drive1,
    output logic       drive2,
    input  logic [7:0] pixData11,
    input  logic [7:0] pixData12,
    input  logic [7:0] pixData21,
    input  logic [7:0] pixData22,
    output logic [7:0] pixOut11,
    output logic [7:0] pixOut12,
    output logic [7:0] pixOut21,
    output logic [7:0] pixOut22,
    output logic       frameValid,
    output logic       busy
);

    // Counter must hold the longest phase length minus one and always be
    // wide enough to supply the 8-bit ramp code.
    localparam int C_MAX_EX = (C_ERASE > C_EXPOSE) ? C_ERASE : C_EXPOSE;
    localparam int C_MAX_CR = (C_CONVERT > C_READ) ? C_CONVERT : C_READ;
    localparam int C_MAX    = (C_MAX_EX > C_MAX_CR) ? C_MAX_EX : C_MAX_CR;
    localparam int CW_RAW   = $clog2(C_MAX) + 1;
    localparam int CW       = (CW_RAW > 9) ? CW_RAW : 9;

    localparam logic [CW-1:0] LAST_ERASE   = CW'(C_ERASE - 1);
    localparam logic [CW-1:0] LAST_EXPOSE  = CW'(C_EXPOSE - 1);
    localparam logic [CW-1:0] LAST_CONVERT = CW'(C_CONVERT - 1);
    localparam logic [CW-1:0] LAST_READ    = CW'(C_READ - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_READ1   = 3'd4,
        S_READ2   = 3'd5,
        S_GAP     = 3'd6
    } state_t;

    state_t          state_q, state_d;
    state_t          ret_q, ret_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            erase_q, erase_d;
    logic            expose_q, expose_d;
    logic            convert_q, convert_d;
    logic            read1_q, read1_d;
    logic            read2_q, read2_d;
    logic            busy_q, busy_d;
    logic            frame_valid_q, frame_valid_d;
    logic [7:0]      ramp_code_q, ramp_code_d;

    logic [7:0]      pix_out11_q, pix_out12_q, pix_out21_q, pix_out22_q;
    logic            cap_row1, cap_row2;
    logic [CW-1:0]   phase_last;
    logic            at_last;

    // Select the terminal count for the phase currently running.
    always_comb begin
        phase_last = '0;
        case (state_q)
            S_ERASE:   phase_last = LAST_ERASE;
            S_EXPOSE:  phase_last = LAST_EXPOSE;
            S_CONVERT: phase_last = LAST_CONVERT;
            S_READ1:   phase_last = LAST_READ;
            S_READ2:   phase_last = LAST_READ;
            default:   phase_last = '0;
        endcase
    end

    assign at_last = (cnt_q == phase_last);

    // Next-state, phase counter and capture strobes.
    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        cnt_d         = cnt_q;
        cap_row1      = 1'b0;
        cap_row2      = 1'b0;
        frame_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_ERASE;
                end
            end
            S_ERASE: begin
                if (at_last) begin
                    state_d = S_GAP;
                    ret_d   = S_EXPOSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXPOSE: begin
                if (at_last) begin
                    state_d = S_GAP;
                    ret_d   = S_CONVERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CONVERT: begin
                if (at_last) begin
                    state_d = S_GAP;
                    ret_d   = S_READ1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ1: begin
                if (at_last) begin
                    state_d  = S_GAP;
                    ret_d    = S_READ2;
                    cnt_d    = '0;
                    cap_row1 = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ2: begin
                if (at_last) begin
                    state_d       = S_IDLE;
                    ret_d         = S_IDLE;
                    cnt_d         = '0;
                    cap_row2      = 1'b1;
                    frame_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                state_d = ret_q;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                ret_d   = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they register in step
    // with the state itself; the ramp follows the counter in CONVERT.
    always_comb begin
        erase_d     = (state_d == S_ERASE);
        expose_d    = (state_d == S_EXPOSE);
        convert_d   = (state_d == S_CONVERT);
        read1_d     = (state_d == S_READ1);
        read2_d     = (state_d == S_READ2);
        busy_d      = (state_d != S_IDLE);
        ramp_code_d = (state_d == S_CONVERT) ? cnt_d[7:0] : 8'd0;
    end

    // State, counter and registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ret_q         <= S_IDLE;
            cnt_q         <= '0;
            erase_q       <= 1'b0;
            expose_q      <= 1'b0;
            convert_q     <= 1'b0;
            read1_q       <= 1'b0;
            read2_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            ramp_code_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            cnt_q         <= cnt_d;
            erase_q       <= erase_d;
            expose_q      <= expose_d;
            convert_q     <= convert_d;
            read1_q       <= read1_d;
            read2_q       <= read2_d;
            busy_q        <= busy_d;
            frame_valid_q <= frame_valid_d;
            ramp_code_q   <= ramp_code_d;
        end
    end

    // Pixel capture on the final cycle of each read phase; held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_out11_q <= 8'd0;
            pix_out12_q <= 8'd0;
            pix_out21_q <= 8'd0;
            pix_out22_q <= 8'd0;
        end else begin
            if (cap_row1) begin
                pix_out11_q <= pixData11;
                pix_out12_q <= pixData12;
            end
            if (cap_row2) begin
                pix_out21_q <= pixData21;
                pix_out22_q <= pixData22;
            end
        end
    end

    assign erase      = erase_q;
    assign expose     = expose_q;
    assign convert    = convert_q;
    assign read1      = read1_q;
    assign read2      = read2_q;
    assign busy       = busy_q;
    assign frameValid = frame_valid_q;
    assign rampCode   = ramp_code_q;
    // Ramp drivers release a row's bus exactly while that row is read out.
    assign drive1     = ~read1_q;
    assign drive2     = ~read2_q;
    assign pixOut11   = pix_out11_q;
    assign pixOut12   = pix_out12_q;
    assign pixOut21   = pix_out21_q;
    assign pixOut22   = pix_out22_q;

endmodule

// File: doc/pixel_sensor_ctrl.md
# pixel_sensor_ctrl

Synthesizable sequencer for the 2x2 `PIXEL_ARRAY`. It generates the erase/expose/convert/read1/read2 control phases and the 8-bit digital ramp code driven onto the pixel data buses during conversion. It also captures the four pixel values during readout and flags a completed frame. It sits between the array and the system, replacing the behavioural testbench FSM and ADC model.

## Interface
Parameters:
- `C_ERASE`, 5: erase phase length, cycles (≥1)
- `C_EXPOSE`, 255: expose phase length, cycles (≥1)
- `C_CONVERT`, 255: convert phase length, cycles (1..256)
- `C_READ`, 5: length of each read phase, cycles (≥1)

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: begin a frame when sampled high in IDLE
- `erase` out 1: pixel ERASE control
- `expose` out 1: pixel EXPOSE control
- `convert` out 1: high during conversion; top level gates `RAMP` with it
- `read1` out 1: row-1 read enable (DATA11/DATA12)
- `read2` out 1: row-2 read enable (DATA21/DATA22)
- `rampCode` out 8: digital ramp value for the data buses
- `drive1` out 1: tristate enable for `rampCode` onto DATA11/12; equals `!read1`
- `drive2` out 1: tristate enable for `rampCode` onto DATA21/22; equals `!read2`
- `pixData11`, `pixData12`, `pixData21`, `pixData22` in 8 each: bus values, sampled during reads
- `pixOut11`, `pixOut12`, `pixOut21`, `pixOut22` out 8 each: captured pixel values
- `frameValid` out 1: one-cycle pulse when all four `pixOut` are updated
- `busy` out 1: high whenever state ≠ IDLE

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, READ1, READ2, GAP. GAP is one cycle with all controls low, inserted between consecutive active phases.
- Sequence: IDLE → ERASE → GAP → EXPOSE → GAP → CONVERT → GAP → READ1 → GAP → READ2 → IDLE.
  - A return-state register selects GAP's successor.
- Phase counter:
  - Cleared on entry to each active state.
  - Increments each cycle in that state.
  - The state exits when counter = C_x − 1, so the phase lasts exactly C_x cycles.
- Controls are registered Moore outputs. Each is high exactly in its own state. At most one of erase/expose/convert/read1/read2 is high at a time.
- Ramp:
  - `rampCode` = phase counter[7:0] while in CONVERT (0,1,2,… in successive cycles).
  - 0 in every other state.
  - No saturation needed: C_CONVERT ≤ 256.
- Capture:
  - On the last READ1 cycle (counter = C_READ−1), register `pixData11` → `pixOut11` and `pixData12` → `pixOut12`.
  - Likewise on the last READ2 cycle for `pixOut21`/`pixOut22`.
  - `pixOut` values are held until the next capture or reset.
- `frameValid` is high for the single cycle after the last READ2 cycle (first cycle back in IDLE).
- `start`:
  - Level-sampled only in IDLE. It is ignored while `busy`.
  - If held high, frames run back-to-back with one IDLE cycle between them.
- Reset, including mid-frame: at the next edge state = IDLE and counter = 0. All outputs go to 0, except `drive1`/`drive2` = 1 (read1/read2 = 0). This covers `pixOut*` = 0, `frameValid` = 0 and `busy` = 0.

## Timing
- Reset values: erase, expose, convert, read1, read2, frameValid, busy = 0; rampCode = 0; pixOut* = 0; drive1 = drive2 = 1.
- `start` sampled high in IDLE at edge n: `erase` and `busy` are high from cycle n+1.
- With default parameters, cycle offsets relative to the first erase cycle (0):
  - erase 0–4; GAP 5
  - expose 6–260; GAP 261
  - convert 262–516 (rampCode 0–254); GAP 517
  - read1 518–522; GAP 523
  - read2 524–528
  - frameValid and busy = 0 at 529
- Back-to-back frame period with default parameters: 530 cycles.
- General frame length: C_ERASE + C_EXPOSE + C_CONVERT + 2·C_READ + 4 cycles.
- `drive1`/`drive2` are combinational inverses of the registered `read1`/`read2`. There is no cycle where both the array and the controller drive a bus.

## Test plan
- Reset then `start` pulse for 1 cycle → control waveform at exactly the offsets above; `busy` high for cycles 0–528; `frameValid` single pulse at 529; no second frame.
- Array model latches `rampCode` at `convert` cycle 37/100/200/254 for pixels 11/12/21/22 → pixOut11 = 37, pixOut12 = 100, pixOut21 = 200, pixOut22 = 254 after frameValid; drive1 = 0 only during cycles 518–522.
- `start` held high → consecutive erase rising edges 530 cycles apart; second frame's pixOut* updates only at its own READ phases.
- `reset` asserted at cycle 300 (mid-CONVERT) → next cycle all controls 0, rampCode = 0, pixOut* = 0, busy = 0; a new `start` gives a clean full frame.
- Parameters C_ERASE = 1, C_EXPOSE = 1, C_CONVERT = 256, C_READ = 1 → rampCode reaches 255 at the last convert cycle; frame length 264 cycles; one-hot controls checked every cycle.
- `start` toggled while busy → ignored; frame timing unchanged.
